// File: rtl/decode_stage.sv
// Single-entry MIPS decode stage: holds one instruction, decodes its fields and
// immediate, picks the destination register and bubbles on load-use hazards.
module decode_stage #(
    parameter int PC_WIDTH  = 32,
    parameter int IMM_WIDTH = 32,
    parameter int LINK_REG  = 31,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 if_valid_i,
    output logic                 if_ready_o,
    input  logic [31:0]          ir_i,
    input  logic [PC_WIDTH-1:0]  pc_i,
    input  logic                 flush_i,
    input  logic                 ex_load_i,
    input  logic [4:0]           ex_rd_i,
    output logic                 id_valid_o,
    input  logic                 id_ready_i,
    output logic [5:0]           opcode_o,
    output logic [4:0]           rs_o,
    output logic [4:0]           rt_o,
    output logic [4:0]           rd_o,
    output logic [4:0]           shamt_o,
    output logic [5:0]           funct_o,
    output logic [IMM_WIDTH-1:0] imm_o,
    output logic [PC_WIDTH-1:0]  pc_o,
    output logic                 stall_o,
    output logic [CNT_WIDTH-1:0] stall_count_o
);

    // Immediates are built at least 32 bits wide so LUI always has room.
    localparam int EXT_W = (IMM_WIDTH > 32) ? IMM_WIDTH : 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [4:0]           LINK_IDX = 5'(LINK_REG);

    logic                 full_q, full_d;
    logic [31:0]          ir_q, ir_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 hazard;
    logic                 accept;
    logic                 issue;
    logic [15:0]          imm16;
    logic [EXT_W-1:0]     sext;
    logic [EXT_W-1:0]     zext;
    logic [EXT_W-1:0]     lui_ext;
    logic [EXT_W-1:0]     imm_ext;

    assign opcode_o = ir_q[31:26];
    assign rs_o     = ir_q[25:21];
    assign rt_o     = ir_q[20:16];
    assign shamt_o  = ir_q[10:6];
    assign funct_o  = ir_q[5:0];
    assign pc_o     = pc_q;

    always_comb begin
        rd_o = ir_q[20:16];
        case (opcode_o)
            OP_RTYPE: rd_o = ir_q[15:11];
            OP_JAL:   rd_o = LINK_IDX;
            default:  rd_o = ir_q[20:16];
        endcase
    end

    always_comb begin
        imm16   = ir_q[15:0];
        sext    = {{(EXT_W-16){imm16[15]}}, imm16};
        zext    = {{(EXT_W-16){1'b0}}, imm16};
        lui_ext = sext << 16;
        case (opcode_o)
            OP_ANDI, OP_ORI, OP_XORI: imm_ext = zext;
            OP_LUI:                   imm_ext = lui_ext;
            default:                  imm_ext = sext;
        endcase
    end

    assign imm_o = imm_ext[IMM_WIDTH-1:0];

    // Matching on rt as well as rs is conservative: some formats never read rt.
    assign hazard = full_q & ex_load_i & (ex_rd_i != 5'd0) &
                    ((ex_rd_i == rs_o) | (ex_rd_i == rt_o));

    assign stall_o       = hazard;
    assign id_valid_o    = full_q & ~hazard;
    assign if_ready_o    = ~full_q | (id_ready_i & ~hazard);
    assign accept        = if_valid_i & if_ready_o & ~flush_i;
    assign issue         = id_valid_o & id_ready_i;
    assign stall_count_o = cnt_q;

    always_comb begin
        full_d = full_q;
        ir_d   = ir_q;
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (accept) begin
            full_d = 1'b1;
            ir_d   = ir_i;
            pc_d   = pc_i;
        end else if (issue) begin
            full_d = 1'b0;
        end
        // Counts even on a flushed hazard cycle; never wraps.
        if (hazard && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            ir_q   <= '0;
            pc_q   <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            ir_q   <= ir_d;
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed literal checks plus a randomized run compared
// every cycle against a behavioural model of the stage.
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        if_valid;
    logic        flush;
    logic        ex_load;
    logic        id_ready;
    logic [4:0]  ex_rd;
    logic [31:0] ir;
    logic [31:0] pc;

    logic        if_ready, id_valid, stall;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm, pc_out;
    logic [15:0] cnt;

    logic        if_ready_s, id_valid_s, stall_s;
    logic [5:0]  opcode_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
    logic [31:0] imm_s, pc_out_s;
    logic [1:0]  cnt_s;

    decode_stage dut (
        .clk_i(clk), .rst_ni(rst_n), .if_valid_i(if_valid), .if_ready_o(if_ready),
        .ir_i(ir), .pc_i(pc), .flush_i(flush), .ex_load_i(ex_load), .ex_rd_i(ex_rd),
        .id_valid_o(id_valid), .id_ready_i(id_ready), .opcode_o(opcode), .rs_o(rs),
        .rt_o(rt), .rd_o(rd), .shamt_o(shamt), .funct_o(funct), .imm_o(imm),
        .pc_o(pc_out), .stall_o(stall), .stall_count_o(cnt)
    );

    decode_stage #(.CNT_WIDTH(2)) dut_small (
        .clk_i(clk), .rst_ni(rst_n), .if_valid_i(if_valid), .if_ready_o(if_ready_s),
        .ir_i(ir), .pc_i(pc), .flush_i(flush), .ex_load_i(ex_load), .ex_rd_i(ex_rd),
        .id_valid_o(id_valid_s), .id_ready_i(id_ready), .opcode_o(opcode_s), .rs_o(rs_s),
        .rt_o(rt_s), .rd_o(rd_s), .shamt_o(shamt_s), .funct_o(funct_s), .imm_o(imm_s),
        .pc_o(pc_out_s), .stall_o(stall_s), .stall_count_o(cnt_s)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_full   = 1'b0;
    logic [31:0] m_ir     = 32'h0;
    logic [31:0] m_pc     = 32'h0;
    int unsigned m_stalls = 0;

    function automatic bit m_hazard();
        return m_full && ex_load && (ex_rd != 5'd0) &&
               (ex_rd == m_ir[25:21] || ex_rd == m_ir[20:16]);
    endfunction

    function automatic logic [4:0] exp_rd(input logic [31:0] w);
        if (w[31:26] == 6'h00) return w[15:11];
        if (w[31:26] == 6'h03) return 5'd31;
        return w[20:16];
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] w);
        logic [5:0]  op;
        logic [31:0] lo;
        op = w[31:26];
        lo = {16'h0, w[15:0]};
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return lo;
        if (op == 6'h0F) return lo * 32'd65536;
        if (lo >= 32'd32768) return lo | 32'hFFFF0000;
        return lo;
    endfunction

    function automatic logic [63:0] sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? 64'(mx) : 64'(v);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full = 1'b0; m_ir = 32'h0; m_pc = 32'h0; m_stalls = 0;
        end else begin
            bit hz, give, take;
            hz   = m_hazard();
            give = m_full && !hz && id_ready;
            take = if_valid && (!m_full || (id_ready && !hz)) && !flush;
            if (hz) m_stalls++;
            if (flush) m_full = 1'b0;
            else if (take) begin m_full = 1'b1; m_ir = ir; m_pc = pc; end
            else if (give) m_full = 1'b0;
        end
    end

    always @(negedge clk) begin
        bit hz;
        hz = m_hazard();
        chk("id_valid", id_valid, m_full && !hz);
        chk("if_ready", if_ready, !m_full || (id_ready && !hz));
        chk("stall", stall, hz);
        chk("opcode", opcode, m_ir[31:26]);
        chk("rs", rs, m_ir[25:21]);
        chk("rt", rt, m_ir[20:16]);
        chk("rd", rd, exp_rd(m_ir));
        chk("shamt", shamt, m_ir[10:6]);
        chk("funct", funct, m_ir[5:0]);
        chk("imm", imm, exp_imm(m_ir));
        chk("pc", pc_out, m_pc);
        chk("stall_count", cnt, sat(m_stalls, 65535));
        chk("w2_id_valid", id_valid_s, m_full && !hz);
        chk("w2_if_ready", if_ready_s, !m_full || (id_ready && !hz));
        chk("w2_stall", stall_s, hz);
        chk("w2_fields", {opcode_s, rs_s, rt_s, shamt_s, funct_s},
            {m_ir[31:26], m_ir[25:21], m_ir[20:16], m_ir[10:6], m_ir[5:0]});
        chk("w2_rd", rd_s, exp_rd(m_ir));
        chk("w2_imm", imm_s, exp_imm(m_ir));
        chk("w2_pc", pc_out_s, m_pc);
        chk("w2_stall_count", cnt_s, sat(m_stalls, 3));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] w, input logic [31:0] p);
        if_valid = 1'b1; ir = w; pc = p; id_ready = 1'b1;
        tick();
        if_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [5:0]  ops [8];
        logic [31:0] w;
        ops = '{6'h00, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23};
        w = $urandom;
        if (($urandom % 8) != 0) w[31:26] = ops[$urandom % 8];
        w[25:21] = 5'($urandom % 4);
        w[20:16] = 5'($urandom % 4);
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; flush = 1'b0; ex_load = 1'b0;
        ex_rd = 5'd0; id_ready = 1'b0; ir = 32'h0; pc = 32'h0;
        tick(); tick();
        chk("rst id_valid", id_valid, 1'b0);
        chk("rst if_ready", if_ready, 1'b1);
        chk("rst stall", stall, 1'b0);
        chk("rst stall_count", cnt, 16'd0);
        chk("rst imm", imm, 32'h0);
        chk("rst pc", pc_out, 32'h0);
        chk("rst rd", rd, 5'd0);
        rst_n = 1'b1;

        load(32'h2008FFFF, 32'h100);
        chk("addi id_valid", id_valid, 1'b1);
        chk("addi rt", rt, 5'd8);
        chk("addi rd", rd, 5'd8);
        chk("addi imm", imm, 32'hFFFFFFFF);
        load(32'h3508FFFF, 32'h104);
        chk("ori imm", imm, 32'h0000FFFF);
        load(32'h3C081234, 32'h108);
        chk("lui imm", imm, 32'h12340000);
        load(32'h00221820, 32'h10C);
        chk("add rs", rs, 5'd1);
        chk("add rt", rt, 5'd2);
        chk("add rd", rd, 5'd3);
        chk("add funct", funct, 6'h20);
        load(32'h0C000010, 32'h110);
        chk("jal rd", rd, 5'd31);
        chk("jal pc", pc_out, 32'h110);

        // streaming, one per cycle
        for (int i = 0; i < 8; i++) begin
            if_valid = 1'b1; id_ready = 1'b1;
            ir = {6'h08, 5'(i), 5'(i + 1), 16'(i * 3)};
            pc = 32'h1000 + 32'(4 * i);
            tick();
            chk("stream id_valid", id_valid, 1'b1);
            chk("stream pc", pc_out, 32'h1000 + 32'(4 * i));
        end
        id_ready = 1'b0; if_valid = 1'b1; ir = 32'hDEADBEEF; pc = 32'h2000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold id_valid", id_valid, 1'b1);
            chk("hold if_ready", if_ready, 1'b0);
            chk("hold pc", pc_out, 32'h101C);
            chk("hold rt", rt, 5'd8);
        end
        if_valid = 1'b0; id_ready = 1'b1;
        tick();

        // load-use hazard on rs: exactly one bubble
        load(32'h00221820, 32'h3000);
        ex_load = 1'b1; ex_rd = 5'd1;
        #1;
        chk("hz stall", stall, 1'b1);
        chk("hz id_valid", id_valid, 1'b0);
        chk("hz if_ready", if_ready, 1'b0);
        chk("hz count before", cnt, 16'd0);
        tick();
        ex_load = 1'b0; ex_rd = 5'd0;
        #1;
        chk("hz count after", cnt, 16'd1);
        chk("hz reissue", id_valid, 1'b1);
        chk("hz reissue pc", pc_out, 32'h3000);
        tick();

        // ex_rd = 0 never stalls
        load(32'h00221820, 32'h3004);
        ex_load = 1'b1; ex_rd = 5'd0;
        #1;
        chk("rd0 stall", stall, 1'b0);
        chk("rd0 id_valid", id_valid, 1'b1);
        tick();
        ex_load = 1'b0;
        chk("rd0 count", cnt, 16'd1);

        // saturation of the 2-bit counter, match on rt
        load(32'h00221820, 32'h3008);
        ex_load = 1'b1; ex_rd = 5'd2;
        repeat (5) tick();
        chk("sat w2 count", cnt_s, 2'd3);
        chk("sat count", cnt, 16'd6);
        chk("sat id_valid", id_valid, 1'b0);
        ex_load = 1'b0; ex_rd = 5'd0;
        tick();

        // flush blocks capture
        load(32'h20090005, 32'h4000);
        if_valid = 1'b1; ir = 32'h200A0007; pc = 32'h4004; flush = 1'b1;
        tick();
        flush = 1'b0; if_valid = 1'b0;
        #1;
        chk("flush id_valid", id_valid, 1'b0);
        chk("flush pc kept", pc_out, 32'h4000);
        chk("flush if_ready", if_ready, 1'b1);

        // flush during hazard still counts
        load(32'h00221820, 32'h5000);
        ex_load = 1'b1; ex_rd = 5'd1; flush = 1'b1;
        tick();
        flush = 1'b0; ex_load = 1'b0; ex_rd = 5'd0;
        #1;
        chk("flush hz id_valid", id_valid, 1'b0);
        chk("flush hz count", cnt, 16'd7);

        // asynchronous reset mid-stream
        load(32'h20090005, 32'h6000);
        chk("pre-reset id_valid", id_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst id_valid", id_valid, 1'b0);
        chk("async rst pc", pc_out, 32'h0);
        chk("async rst count", cnt, 16'd0);
        tick();
        rst_n = 1'b1;

        // randomized run, checked each cycle by the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            if_valid = ($urandom % 4) != 0;
            id_ready = ($urandom % 4) != 0;
            flush    = ($urandom % 16) == 0;
            ex_load  = ($urandom % 3) == 0;
            ex_rd    = 5'($urandom % 4);
            ir       = rand_ir();
            pc       = $urandom;
            if (c == 1500) begin
                #2 rst_n = 1'b0;
            end else if (c == 1502) begin
                rst_n = 1'b1;
            end
        end
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
